// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Operand-forwarding scoreboard between the register-file read and the ALU
//   operand muxes. Keeps a shift-register history of the last DEPTH
//   result-producing instructions (stage 0 = youngest) and, for each source
//   port, returns the youngest in-flight value or the register-file value.
//   Load results become ready when memory data arrives at stage LOAD_STAGE.
//   A read that hits a not-yet-ready producer raises a load-use stall. Stall
//   cycles are counted with saturation.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   hold             freeze history (load capture still happens in place)
//   issue_*          instruction leaving EX this cycle
//   ld_valid/ld_data load data for the pending entry in stage LOAD_STAGE
//   readAddr/rfData  packed per-port source indices and register-file values
//   operand/fwdHit   packed per-port resolved operands and forward flags
//   stall            some port depends on a not-ready producer
//   stallCount       saturating count of stall cycles
module fwd_scoreboard #(
    parameter int WORD_LEN      = 32,
    parameter int REG_IDX_WIDTH = 5,
    parameter int NUM_READ      = 2,
    parameter int DEPTH         = 3,
    parameter int LOAD_STAGE    = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              hold,
    input  logic                              issue_valid,
    input  logic                              issue_regWrite,
    input  logic                              issue_isLoad,
    input  logic [REG_IDX_WIDTH-1:0]          issue_rd,
    input  logic [WORD_LEN-1:0]               issue_data,
    input  logic                              ld_valid,
    input  logic [WORD_LEN-1:0]               ld_data,
    input  logic [NUM_READ*REG_IDX_WIDTH-1:0] readAddr,
    input  logic [NUM_READ*WORD_LEN-1:0]      rfData,
    output logic [NUM_READ*WORD_LEN-1:0]      operand,
    output logic [NUM_READ-1:0]               fwdHit,
    output logic                              stall,
    output logic [CNT_WIDTH-1:0]              stallCount
);

    typedef struct packed {
        logic                     valid;
        logic                     ready;
        logic [REG_IDX_WIDTH-1:0] rd;
        logic [WORD_LEN-1:0]      data;
    } entry_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    entry_t hist [DEPTH];   // registered history
    entry_t cur  [DEPTH];   // history with this cycle's load capture applied
    entry_t cap;            // entry entering stage 0 on a shift
    logic   ld_capture;

    // Load capture is folded into the current view of the history so that
    // both the in-place (hold) update and the shifted copy see it.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first; a path that leaves one unassigned would infer a latch.
        ld_capture = ld_valid && hist[LOAD_STAGE].valid && !hist[LOAD_STAGE].ready;
        for (int k = 0; k < DEPTH; k++) begin
            cur[k] = hist[k];
        end
        if (ld_capture) begin
            cur[LOAD_STAGE].ready = 1'b1;
            cur[LOAD_STAGE].data  = ld_data;
        end

        cap = '0;
        if (issue_valid && issue_regWrite) begin
            cap.valid = 1'b1;
            cap.rd    = issue_rd;
            cap.ready = !issue_isLoad;
            cap.data  = issue_isLoad ? '0 : issue_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the shift register into a single stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the history is reset entry by entry because a stale valid
            // bit would forward garbage after reset.
            for (int k = 0; k < DEPTH; k++) begin
                hist[k] <= '0;
            end
            stallCount <= '0;
        end else begin
            if (hold) begin
                hist <= cur;
            end else begin
                hist[0] <= cap;
                for (int k = 1; k < DEPTH; k++) begin
                    hist[k] <= cur[k-1];
                end
            end
            if (stall && stallCount != '1) begin
                stallCount <= stallCount + CNT_ONE;
            end
        end
    end

    // Per-port resolution. The stage scan runs oldest to youngest so the last
    // match, i.e. the lowest index, wins; rd 0 is never live.
    logic [REG_IDX_WIDTH-1:0] addr;
    logic                     hit;
    logic                     sel_at_ld;
    entry_t                   sel;
    logic [NUM_READ-1:0]      unresolved;

    always_comb begin
        operand    = rfData;
        fwdHit     = '0;
        unresolved = '0;
        addr       = '0;
        hit        = 1'b0;
        sel_at_ld  = 1'b0;
        sel        = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            addr      = readAddr[p*REG_IDX_WIDTH +: REG_IDX_WIDTH];
            hit       = 1'b0;
            sel_at_ld = 1'b0;
            sel       = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (hist[k].valid && hist[k].rd != '0 && hist[k].rd == addr) begin
                    hit       = 1'b1;
                    sel       = hist[k];
                    sel_at_ld = (k == LOAD_STAGE);
                end
            end
            if (hit) begin
                if (sel.ready) begin
                    operand[p*WORD_LEN +: WORD_LEN] = sel.data;
                    fwdHit[p]                       = 1'b1;
                end else if (sel_at_ld && ld_valid) begin
                    // Load data arriving this cycle is bypassed straight through.
                    operand[p*WORD_LEN +: WORD_LEN] = ld_data;
                    fwdHit[p]                       = 1'b1;
                end else begin
                    unresolved[p] = 1'b1;
                end
            end
        end
        stall = |unresolved;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding scoreboard for the pipelined core, sitting between the register file read and the ALU operand muxes. It holds a shift-register history of the last DEPTH result-producing instructions (destination index, readiness, result value). It returns, for each of NUM_READ source ports, the youngest in-flight value or the register-file value. Load results become ready only when memory data arrives. Reads that hit a not-yet-ready producer raise a load-use stall, and the stalls are counted.

## Interface
Parameters:
- WORD_LEN, 32, data width
- REG_IDX_WIDTH, 5, register index width
- NUM_READ, 2, number of source read ports (≥1)
- DEPTH, 3, tracked in-flight stages (≥2); stage 0 youngest
- LOAD_STAGE, 1, stage index at which load data is delivered (1..DEPTH-1)
- CNT_WIDTH, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  freeze history (no shift)
- issue_valid  in  1  instruction leaving EX this cycle
- issue_regWrite  in  1  it writes a register
- issue_isLoad  in  1  result comes from memory
- issue_rd  in  REG_IDX_WIDTH  destination index
- issue_data  in  WORD_LEN  ALU result (ignored for loads)
- ld_valid  in  1  load data valid for the entry in stage LOAD_STAGE
- ld_data  in  WORD_LEN  load data
- readAddr  in  NUM_READ*REG_IDX_WIDTH  source indices, port p at [p*REG_IDX_WIDTH +: REG_IDX_WIDTH]
- rfData  in  NUM_READ*WORD_LEN  register-file values, same packing
- operand  out  NUM_READ*WORD_LEN  resolved operands
- fwdHit  out  NUM_READ  port p took a forwarded value
- stall  out  1  some port depends on a not-ready producer
- stallCount  out  CNT_WIDTH  saturating count of stall cycles

## Operation
- Entry fields: valid, rd, ready, data. An entry is live only if valid && rd != 0.
- Capture at stage 0 when issue_valid && issue_regWrite:
  - valid=1, rd=issue_rd.
  - Non-load: ready=1, data=issue_data.
  - Load: ready=0, data=0.
- Capture otherwise: a bubble, valid=0.
- Shift on each clock edge with !hold: stage k+1 ← stage k; stage DEPTH-1 is discarded.
- With hold=1:
  - No shift.
  - Issue inputs are ignored.
  - Load capture still occurs in place.
- Load capture: if ld_valid and the stage-LOAD_STAGE entry is valid && !ready, it gets data=ld_data, ready=1.
  - Without hold, the updated entry lands in stage LOAD_STAGE+1.
  - If LOAD_STAGE = DEPTH-1 and there is no hold, the entry is discarded.
  - ld_valid with no pending load in LOAD_STAGE is ignored.
- A load that reaches stage > LOAD_STAGE still not ready stays not ready. This is a protocol error: the entry stalls any matching reader until it ages out.
- Per port p (combinational):
  - Select the lowest-index live entry with rd == readAddr[p].
  - If none: operand=rfData[p], fwdHit[p]=0.
  - If it is ready: operand=its data, fwdHit[p]=1.
  - If it is not ready, sits in LOAD_STAGE, and ld_valid=1: operand=ld_data, fwdHit[p]=1 (same-cycle bypass).
  - Otherwise: operand=rfData[p], fwdHit[p]=0, port unresolved.
  - readAddr 0 never matches: operand=rfData[p].
- stall = OR of unresolved ports. The block does not freeze itself on stall. Upstream inserts a bubble (issue_valid=0) and history keeps advancing unless hold.
- stallCount increments on each clock edge with stall=1, saturating at all-ones.

## Timing
- Reset (rst=1 at edge): all entries valid=0, ready=0, rd=0, data=0; stallCount=0.
- After reset, with no live entries: operand=rfData, fwdHit=0, stall=0.
- rst takes priority over hold, issue and ld capture.
- operand, fwdHit and stall are combinational from state, readAddr, rfData, ld_valid and ld_data. There is no added latency.
- An issued result is forwardable starting the cycle after its capture edge, and remains so for DEPTH cycles absent hold.
- Simultaneous capture and shift: load capture applies to the entry being shifted. The issue capture at stage 0 is independent.
- Two live entries with the same rd: the younger (lower index) wins even if not ready, which gives a stall, never stale data.

## Test plan
- Reset then readAddr0=5, rfData0=0xAAAA → operand0=0xAAAA, fwdHit=0, stall=0, stallCount=0.
- Issue rd=5 data=0x11, next cycle issue rd=5 data=0x22, then read 5 → operand0=0x22. After DEPTH more bubble cycles → operand0=rfData.
- Issue load rd=7, then read 7 on both ports with ld_valid=0 → stall=1, stallCount increments. Next cycle at LOAD_STAGE with ld_valid=1, ld_data=0x1234 → operand=0x1234, fwdHit=2'b11, stall=0. The following cycle → 0x1234 from the stored entry.
- Issue rd=0 data=0xFF, then read 0 → operand=rfData, fwdHit=0.
- hold=1 for 3 cycles with a live rd=3 entry at stage 0 → still forwarded and issue ignored. Release hold → entry advances.
- Force 2^CNT_WIDTH+5 stall cycles (small CNT_WIDTH build) → stallCount saturates at all-ones. rst mid-stall → stall=0, stallCount=0 next cycle.
